// File: rtl/dma_copy.sv
// Single-channel word-copy DMA: SRC/DST/CNT/CTRL register port plus a master bus port.
// Optional macro DMA_COPY_IRQ_EN adds the IE bit and a registered completion interrupt.
module dma_copy (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        irq,
  output logic        m_stb,
  output logic        m_we,
  output logic [21:0] m_addr,
  input  logic [31:0] m_din,
  output logic [31:0] m_dout,
  input  logic        m_ack
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t      state_q, state_d;
  logic [21:0] src_q, src_d;
  logic [21:0] dst_q, dst_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [31:0] buf_q, buf_d;
  logic        m_stb_q, m_stb_d;
  logic        m_we_q, m_we_d;
  logic [21:0] m_addr_q, m_addr_d;

  logic busy;
  logic reg_wr;
  logic ctrl_wr;
  logic ie;
  logic unused_hi;

  assign busy      = (state_q != IDLE);
  assign reg_wr    = stb & we;
  assign ctrl_wr   = reg_wr & (addr == 2'd3);
  assign ack       = stb;
  assign m_stb     = m_stb_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_dout    = buf_q;
  assign unused_hi = ^data_in[31:22];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      buf_q    <= '0;
      m_stb_q  <= 1'b0;
      m_we_q   <= 1'b0;
      m_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      buf_q    <= buf_d;
      m_stb_q  <= m_stb_d;
      m_we_q   <= m_we_d;
      m_addr_q <= m_addr_d;
    end
  end

  // Each bus cycle is issued from a cycle with m_stb low, which guarantees the idle gap.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    buf_d    = buf_q;
    m_stb_d  = m_stb_q;
    m_we_d   = m_we_q;
    m_addr_d = m_addr_q;

    if (reg_wr && !busy) begin
      case (addr)
        2'd0:    src_d = data_in[21:0];
        2'd1:    dst_d = data_in[21:0];
        2'd2:    cnt_d = data_in[15:0];
        default: ;
      endcase
    end
    if (ctrl_wr && data_in[1]) done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ctrl_wr && data_in[0]) state_d = (cnt_q != 16'd0) ? RD : FIN;
      end
      RD: begin
        if (!m_stb_q) begin
          m_stb_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = src_q;
        end else if (m_ack) begin
          buf_d   = m_din;
          m_stb_d = 1'b0;
          state_d = WR;
        end
      end
      WR: begin
        if (!m_stb_q) begin
          m_stb_d  = 1'b1;
          m_we_d   = 1'b1;
          m_addr_d = dst_q;
        end else if (m_ack) begin
          m_stb_d = 1'b0;
          m_we_d  = 1'b0;
          src_d   = src_q + 22'd1;
          dst_d   = dst_q + 22'd1;
          cnt_d   = cnt_q - 16'd1;
          state_d = (cnt_q != 16'd1) ? RD : FIN;
        end
      end
      FIN: begin
        // Assigned after the clear above so a simultaneous clear loses.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_out = '0;
    case (addr)
      2'd0:    data_out = {10'd0, src_q};
      2'd1:    data_out = {10'd0, dst_q};
      2'd2:    data_out = {16'd0, cnt_q};
      default: data_out = {29'd0, ie, done_q, busy};
    endcase
  end

`ifdef DMA_COPY_IRQ_EN
  logic ie_q, ie_d;
  logic irq_q;

  always_comb begin
    ie_d = ie_q;
    if (ctrl_wr) ie_d = data_in[2];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= done_q & ie_q;
    end
  end

  assign ie  = ie_q;
  assign irq = irq_q;
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: slave model with programmable ack delay, transfer
// scoreboard built from SRC/DST/CNT, and a per-cycle bus-protocol compare process.
`timescale 1ns/1ps
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        ack;
  logic        irq;
  logic        m_stb;
  logic        m_we;
  logic [21:0] m_addr;
  logic [31:0] m_din = 32'd0;
  logic [31:0] m_dout;
  logic        m_ack = 1'b0;

  dma_copy dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .irq      (irq),
    .m_stb    (m_stb),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_din    (m_din),
    .m_dout   (m_dout),
    .m_ack    (m_ack)
  );

  always #10 clk = ~clk;

`ifdef DMA_COPY_IRQ_EN
  localparam logic [31:0] IE_RD = 32'h4;
`else
  localparam logic [31:0] IE_RD = 32'h0;
`endif

  typedef struct {
    logic        we;
    logic [21:0] addr;
    logic [31:0] data;
    int          run;
  } txn_t;

  txn_t exp_q[$];
  txn_t log_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_delay = 1;
  int   wait_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [21:0] a);
    return 32'h5A00_0000 ^ {10'd0, a} ^ {a[9:0], 22'd0};
  endfunction

  function automatic void push_transfer(input logic [21:0] s, input logic [21:0] d, input int n);
    txn_t t;
    for (int i = 0; i < n; i++) begin
      t.we   = 1'b0;
      t.addr = s + 22'(i);
      t.data = mem_word(t.addr);
      t.run  = 0;
      exp_q.push_back(t);
      t.we   = 1'b1;
      t.addr = d + 22'(i);
      exp_q.push_back(t);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    stb = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    stb = 1'b1; we = 1'b0; addr = a;
    #1;
    d = data_out;
    chk("ack_follows_stb", 32'(ack), 32'd1);
    stb = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] c;
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      rd(2'd3, c);
      if (!c[0]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle actual=busy required=idle within %0d cycles", budget);
    end
  endtask

  // Slave: acknowledges after ack_delay cycles of m_stb, returns mem_word of the address.
  always @(negedge clk) begin
    m_din = mem_word(m_addr);
    if (m_stb && !m_ack) begin
      if (wait_cnt >= ack_delay) begin
        m_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      m_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  logic        prev_rst_ok = 1'b0;
  logic        prev_stb = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_we = 1'b0;
  logic [21:0] prev_addr = '0;
  int          run_len = 0;

  always @(negedge clk) begin
    txn_t got;
    txn_t e;
    #2;
    if (prev_rst_ok && prev_stb && !prev_ack) begin
      chk("stb_hold", 32'(m_stb), 32'd1);
      chk("addr_hold", 32'(m_addr), 32'(prev_addr));
      chk("we_hold", 32'(m_we), 32'(prev_we));
    end
    if (prev_rst_ok && prev_stb && prev_ack) chk("stb_gap", 32'(m_stb), 32'd0);
    if (m_stb) run_len++;
    else run_len = 0;
    if (rst_n && m_stb && m_ack) begin
      got.we   = m_we;
      got.addr = m_addr;
      got.data = m_we ? m_dout : m_din;
      got.run  = run_len;
      log_q.push_back(got);
      $display("txn %s addr=0x%06h data=0x%08h stb_cycles=%0d", m_we ? "WR" : "RD", m_addr, got.data, run_len);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_txn actual=addr 0x%06h required=no bus cycle", m_addr);
      end else begin
        e = exp_q.pop_front();
        chk("txn_we", 32'(m_we), 32'(e.we));
        chk("txn_addr", 32'(m_addr), 32'(e.addr));
        if (e.we) chk("txn_data", m_dout, e.data);
      end
    end
    prev_rst_ok = rst_n;
    prev_stb    = m_stb;
    prev_ack    = m_ack;
    prev_we     = m_we;
    prev_addr   = m_addr;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1, "timeout");
  end

  logic [31:0] v;
  logic [21:0] t1_addr [6];
  bit          found;

  initial begin
    t1_addr = '{22'h100, 22'h200, 22'h101, 22'h201, 22'h102, 22'h202};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    rd(2'd0, v); chk("rst_src", v, 32'd0);
    rd(2'd1, v); chk("rst_dst", v, 32'd0);
    rd(2'd2, v); chk("rst_cnt", v, 32'd0);
    rd(2'd3, v); chk("rst_ctrl", v, 32'd0);
    chk("rst_mstb", 32'(m_stb), 32'd0);
    chk("rst_maddr", 32'(m_addr), 32'd0);
    chk("rst_mdout", m_dout, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("ack_idle", 32'(ack), 32'd0);

    // Three-word copy, slave acks after one cycle
    ack_delay = 1;
    wr(2'd0, 32'h100); wr(2'd1, 32'h200); wr(2'd2, 32'd3);
    rd(2'd2, v); chk("t1_cnt_rd", v, 32'd3);
    push_transfer(22'h100, 22'h200, 3);
    log_q.delete();
    wr(2'd3, 32'h1);
    wait_idle(200);
    chk("t1_ntxn", 32'(log_q.size()), 32'd6);
    if (log_q.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t1_addr_seq", 32'(log_q[i].addr), 32'(t1_addr[i]));
      chk("t1_wdata0", log_q[1].data, 32'h1A00_0100);
      chk("t1_wdata2", log_q[5].data, 32'h1A80_0102);
      chk("t1_stb_cycles", 32'(log_q[0].run), 32'd2);
    end
    rd(2'd3, v); chk("t1_ctrl_done", v, 32'h2);
    rd(2'd2, v); chk("t1_cnt_end", v, 32'd0);
    rd(2'd0, v); chk("t1_src_end", v, 32'h103);
    rd(2'd1, v); chk("t1_dst_end", v, 32'h203);
    @(negedge clk);
    chk("t1_irq_off", 32'(irq), 32'd0);

    // Zero-count start: FIN without a bus cycle
    wr(2'd3, 32'h2);
    rd(2'd3, v); chk("t2_cleared", v, 32'h0);
    wr(2'd2, 32'd0);
    log_q.delete();
    wr(2'd3, 32'h1);
    rd(2'd3, v); chk("t2_fin_busy", v, 32'h1);
    @(negedge clk);
    rd(2'd3, v); chk("t2_done", v, 32'h2);
    repeat (10) begin
      @(negedge clk);
      chk("t2_no_stb", 32'(m_stb), 32'd0);
    end
    chk("t2_ntxn", 32'(log_q.size()), 32'd0);

    // DONE set in FIN beats a simultaneous clear
    wr(2'd3, 32'h2);
    wr(2'd3, 32'h1);
    wr(2'd3, 32'h2);
    rd(2'd3, v); chk("t3_set_wins", v, 32'h2);
    wr(2'd3, 32'h2);
    rd(2'd3, v); chk("t3_clear", v, 32'h0);

    // Address wrap at 2^22
    wr(2'd0, 32'h3F_FFFF); wr(2'd1, 32'h10); wr(2'd2, 32'd2);
    push_transfer(22'h3F_FFFF, 22'h10, 2);
    log_q.delete();
    wr(2'd3, 32'h1);
    wait_idle(200);
    chk("t4_ntxn", 32'(log_q.size()), 32'd4);
    if (log_q.size() == 4) begin
      chk("t4_rd2_addr", 32'(log_q[2].addr), 32'h0);
      chk("t4_rd2_we", 32'(log_q[2].we), 32'd0);
    end
    rd(2'd0, v); chk("t4_src_wrap", v, 32'h1);

    // Slow slave; writes while busy are ignored
    ack_delay = 5;
    wr(2'd0, 32'h50); wr(2'd1, 32'h60); wr(2'd2, 32'd1);
    push_transfer(22'h50, 22'h60, 1);
    log_q.delete();
    wr(2'd3, 32'h1);
    wr(2'd0, 32'h777);
    wr(2'd2, 32'd9);
    wait_idle(300);
    chk("t5_ntxn", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) chk("t5_stb_cycles", 32'(log_q[0].run), 32'd6);
    rd(2'd0, v); chk("t5_src", v, 32'h51);
    rd(2'd1, v); chk("t5_dst", v, 32'h61);
    rd(2'd2, v); chk("t5_cnt", v, 32'd0);

    // Reset during the write of word 2 of 4
    ack_delay = 3;
    wr(2'd0, 32'h400); wr(2'd1, 32'h500); wr(2'd2, 32'd4);
    push_transfer(22'h400, 22'h500, 4);
    log_q.delete();
    wr(2'd3, 32'h1);
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (m_stb && m_we && log_q.size() == 3) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("t6_reached_wr2", 32'(found), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_stb_drop", 32'(m_stb), 32'd0);
    chk("t6_we_drop", 32'(m_we), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    rd(2'd0, v); chk("t6_src", v, 32'd0);
    rd(2'd1, v); chk("t6_dst", v, 32'd0);
    rd(2'd2, v); chk("t6_cnt", v, 32'd0);
    rd(2'd3, v); chk("t6_ctrl", v, 32'd0);
    chk("t6_mdout", m_dout, 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("t6_quiet", 32'(m_stb), 32'd0);
    end

    // IE bit readback
    wr(2'd3, 32'h4);
    rd(2'd3, v); chk("t7_ie_rd", v, IE_RD);

`ifdef DMA_COPY_IRQ_EN
    ack_delay = 1;
    wr(2'd0, 32'h20); wr(2'd1, 32'h30); wr(2'd2, 32'd1);
    push_transfer(22'h20, 22'h30, 1);
    wr(2'd3, 32'h5);
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      rd(2'd3, v);
      if (v[1]) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("t8_done_seen", 32'(found), 32'd1);
    chk("t8_irq_lag", 32'(irq), 32'd0);
    @(negedge clk);
    chk("t8_irq_rise", 32'(irq), 32'd1);
    wr(2'd3, 32'h2);
    @(negedge clk);
    chk("t8_irq_drop", 32'(irq), 32'd0);
`else
    @(negedge clk);
    chk("t8_irq_tied", 32'(irq), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_copy.md
DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 clk  in  1  system clock, 50 MHz; all logic on rising edge.
REQ-002 rst_n  in  1  reset; synchronous and active-low.
REQ-003 stb  in  1  register-port strobe from the address decoder.
REQ-004 we  in  1  register-port write enable.
REQ-005 addr  in  2  register select, bus_addr[3:2].
REQ-006 data_in  in  32  register write data.
REQ-007 data_out  out  32  register read data.
REQ-008 ack  out  1  register-port acknowledge.
REQ-009 irq  out  1  completion interrupt request, level.
REQ-010 m_stb  out  1  master bus strobe.
REQ-011 m_we  out  1  master write enable.
REQ-012 m_addr  out  22  master word address, bus address bits [23:2].
REQ-013 m_din  in  32  master read data.
REQ-014 m_dout  out  32  master write data.
REQ-015 m_ack  in  1  master acknowledge from the addressed slave.

Function
REQ-016 Registers: 0=SRC[21:0], 1=DST[21:0], 2=CNT[15:0] in words, 3=CTRL.
REQ-017 CTRL write: bit0=1 starts a transfer; bit1=1 clears DONE; bit2 sets IE.
REQ-018 CTRL read: bit0=BUSY, bit1=DONE, bit2=IE, other bits 0; reads of SRC, DST and CNT return live values, zero-extended.
REQ-019 ack = stb, combinational; zero wait states.
REQ-020 Writes to SRC, DST, CNT and CTRL bit0 while BUSY are ignored; writes to IE and to the DONE-clear bit always take effect.
REQ-021 FSM states: IDLE, RD, WR, FIN.
REQ-022 IDLE->RD on a start write with CNT!=0; IDLE->FIN on a start write with CNT==0, with no bus cycle issued.
REQ-023 RD: m_stb=1, m_we=0, m_addr=SRC, held until m_ack; on m_ack, latch m_din into the data buffer, then go to WR.
REQ-024 WR: m_stb=1, m_we=1, m_addr=DST, m_dout=buffer, held until m_ack.
REQ-025 On m_ack in WR: SRC+=1, DST+=1, CNT-=1; next state is RD if the new CNT!=0, otherwise FIN.
REQ-026 m_stb deasserts for at least one cycle between any two bus cycles.
REQ-027 FIN: set DONE, then go to IDLE in the next cycle.
REQ-028 BUSY=1 in RD, WR and FIN.
REQ-029 SRC and DST wrap modulo 2^22; 0x3FFFFF+1 = 0x000000.
REQ-030 A CTRL write that clears DONE in the same cycle FIN sets it: set wins.
REQ-031 m_stb, m_we and m_addr are registered outputs; m_stb=0 in IDLE and FIN.
REQ-032 m_ack is ignored while m_stb=0.
REQ-033 Register-port access during a transfer does not stall the FSM.

Reset
REQ-034 When rst_n=0 at a clock edge: state=IDLE; SRC=DST=CNT=0; DONE=IE=0; buffer=0; m_stb=m_we=0; m_addr=0; m_dout=0; irq=0.
REQ-035 Reset asserted mid-transfer aborts the transfer at that edge; m_stb=0 from the next cycle; no partial register update occurs afterwards.

Configuration
REQ-036 Macro DMA_COPY_IRQ_EN defined: irq = DONE & IE, registered, asserted the cycle after DONE sets.
REQ-037 DMA_COPY_IRQ_EN undefined: irq is tied to 0, the IE bit is not implemented and CTRL bit2 reads 0; all other behaviour is identical.

Verification
REQ-038 SRC=0x000100, DST=0x000200, CNT=3, start; slave acks after 1 cycle -> reads at 0x100, 0x101, 0x102 and writes at 0x200, 0x201, 0x202 with matching data; then DONE=1, CNT=0, SRC=0x103.
REQ-039 CNT=0, start -> no m_stb for 10 cycles; DONE=1 two cycles after the start write.
REQ-040 SRC=0x3FFFFF, CNT=2 -> second read at m_addr=0x000000.
REQ-041 Slave delays m_ack by 5 cycles -> m_stb and m_addr stay stable for the whole wait; exactly one word is transferred.
REQ-042 Drive rst_n low during WR of word 2 of 4 -> m_stb=0 the next cycle; all registers read 0 and BUSY=0.
REQ-043 With DMA_COPY_IRQ_EN defined, IE=1 and CNT=1 -> irq rises one cycle after DONE; a CTRL write of 0x2 drops irq the next cycle.
